ws2812_frame_ctrl: RTL and testbench
====================================

// Module: ws2812_frame_ctrl
// PURPOSE
//  Bus-mapped frame controller that sequences the ws2812 driver core. Holds a NUM_LEDS x 24b
//  framebuffer and applies global brightness scaling. Streams whole frames into the core's
//  led_num/rgb_data/write port on CPU commit, or periodically when auto-refresh is enabled.
//  Sits between the SoC peripheral bus and one ws2812 instance.
// PARAMETERS
//  NUM_LEDS  64  LEDs in chain (1..256); must match the driven ws2812 core
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   synchronous, active-low reset
//  addr        in   9   word address; addr[8]=1 -> framebuffer entry addr[7:0], else register
//  wdata       in   32  write data
//  wen         in   1   single-cycle write strobe
//  ren         in   1   single-cycle read strobe
//  rdata       out  32  read data, valid when ready=1
//  ready       out  1   one-cycle pulse: read data valid / write accepted
//  led_num     out  8   to ws2812 led_num
//  rgb_data    out  24  to ws2812 rgb_data, brightness-scaled
//  write       out  1   to ws2812 write, one cycle per LED
//  busy        out  1   frame stream in progress (mirror of STATUS.busy)
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): rdata=0, ready=0, led_num=0, rgb_data=0, write=0, busy=0;
//   CTRL=0x0000FF00 (brightness 255, auto off), PERIOD=0, frame_cnt=0, pending=0, state=IDLE.
//   Framebuffer contents not reset. Reset mid-stream aborts at once; no further write pulses.
//  Registers (addr[8]=0): 0x00 CTRL rw [0]=auto_en [1]=commit (W1, self-clearing, reads 0)
//   [15:8]=brightness; 0x01 STATUS ro [0]=busy [1]=pending [15:8]=frame_cnt; 0x02 PERIOD rw
//   [23:0] refresh ticks. Unmapped reads return 0; unmapped writes ignored.
//  Bus: wen -> ready next cycle, always accepted. Register ren -> rdata+ready next cycle.
//   wen and ren both high -> write wins; read ignored, no ready for it.
//   FB ren -> rdata[23:0] (unscaled) + ready next cycle, rdata[31:24]=0.
//   Index >= NUM_LEDS: writes dropped, reads return 0; ready still pulses.
//  FB RAM: simple dual-port; port A = CPU writes, port B = reads shared by CPU and streamer.
//   Arbitration on port B is fixed priority, CPU first. A CPU FB read stalls the streamer one
//   cycle; no LED is skipped or duplicated.
//  Commit sources: CTRL.commit write, or auto timer. While auto_en=1 and PERIOD!=0, the timer
//   loads PERIOD, decrements each cycle and, at 0, raises pending and reloads.
//   auto_en=0 or PERIOD=0 holds the timer idle. A PERIOD write reloads the timer.
//  pending is one deep. A commit while pending=1 is merged, not queued.
//  FSM: IDLE --pending--> STREAM (clear pending, idx=0, busy=1).
//   STREAM: issue one port-B read per un-stalled cycle, idx 0..NUM_LEDS-1; after the last
//   issue -> DRAIN.
//   DRAIN: wait for the pipeline to empty, frame_cnt+=1 (8b, wraps 255->0), busy=0 -> IDLE.
//   A commit arriving during STREAM/DRAIN sets pending; IDLE then restarts STREAM next cycle.
//  Pipeline: read issue (c0) -> RAM data (c1) -> scale+register outputs (c2).
//   write=1 with led_num=idx at c2. Latency issue->write is 2 cycles.
//   Unstalled frame: NUM_LEDS write pulses on consecutive cycles.
//  Scaling per 8b channel: out = (c * (bright+1)) >> 8, 16b intermediate.
//   bright=255 is identity; bright=0 gives out=0. Brightness is sampled at STREAM entry and
//   held for the whole frame.
//  CPU FB writes during a stream are allowed. The LED already read uses the old value (tearing
//   permitted). Same-cycle write+read of one entry returns the old data.
// STRUCTURE
//  Include ws2812_ctrl_defs.vh: register addresses, CTRL/STATUS bit positions,
//   FSM state encodings (IDLE/STREAM/DRAIN).
//  Sub-module ws2812_scale: registered 24b x 8b per-channel brightness scaler (1 cycle).
//  Framebuffer inferred as BRAM in the top module; no reset on its contents.
// TESTING
//  T1 reset: hold reset_n=0 3 cycles mid-stream -> write=0 next cycle, busy=0, CTRL reads
//   0x0000FF00.
//  T2 commit: fill fb[i]=i*0x010101, bright=255, write CTRL=0x0000FF02 -> 64 consecutive write
//   pulses, led_num 0..63, rgb_data=fb[i]; STATUS.frame_cnt=1.
//  T3 scaling: fb[0]=0xFF8001, bright=127 -> rgb_data=0x7F4000; bright=0 -> 0x000000.
//  T4 arbitration: FB read of index 5 issued every 3rd cycle during a stream -> each read
//   returns the correct data next cycle; all 64 LEDs written exactly once, in order.
//  T5 auto-refresh: PERIOD=1000, auto_en=1 -> frames start every 1000 cycles; a commit during
//   busy sets pending, yielding one extra back-to-back frame, never two.
//  T6 bounds: write fb index 200 with NUM_LEDS=64 -> ignored, readback 0, ready pulses;
//   frame_cnt wraps 255->0.

Source files
------------

// File: rtl/ws2812_frame_ctrl_pkg.sv
// ws2812_frame_ctrl_pkg
// Shared definitions for the ws2812 frame controller: register map, CTRL bit
// positions, register layouts, FSM state encodings and the per-channel
// brightness scaling helper.
package ws2812_frame_ctrl_pkg;

  // Register word addresses (addr[8] = 0)
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_PERIOD = 8'h02;

  // CTRL write-side bit positions
  localparam int CTRL_AUTO_BIT   = 0;
  localparam int CTRL_COMMIT_BIT = 1;

  // Brightness after reset: full scale, i.e. identity
  localparam logic [7:0] BRIGHT_RESET = 8'hFF;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Read-side layout of CTRL; commit always reads back as 0
  typedef struct packed {
    logic [15:0] rsvd1;
    logic [7:0]  bright;
    logic [5:0]  rsvd0;
    logic        commit;
    logic        auto_en;
  } ctrl_t;

  // Read-side layout of STATUS
  typedef struct packed {
    logic [15:0] rsvd1;
    logic [7:0]  frame_cnt;
    logic [5:0]  rsvd0;
    logic        pending;
    logic        busy;
  } status_t;

  // out = (c * (bright + 1)) >> 8 with a 16-bit product, so bright=255 is an
  // exact identity and bright=0 always yields 0.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_scale.sv
// ws2812_frame_ctrl_scale
// Registered 24b x 8b brightness scaler; last stage of the LED stream pipeline.
// One cycle of latency; its registered outputs drive the ws2812 core directly.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   in_valid       framebuffer data for in_idx is present on in_rgb this cycle
//   in_idx         LED index travelling with the data
//   in_rgb         unscaled 24b colour from the framebuffer
//   bright         brightness held for the current frame
//   out_valid      one-cycle write strobe to the core
//   out_idx        led_num to the core
//   out_rgb        scaled colour to the core
import ws2812_frame_ctrl_pkg::*;

module ws2812_frame_ctrl_scale (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_idx,
  input  logic [23:0] in_rgb,
  input  logic [7:0]  bright,
  output logic        out_valid,
  output logic [7:0]  out_idx,
  output logic [23:0] out_rgb
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_idx   <= 8'h00;
      out_rgb   <= 24'h000000;
    end else begin
      out_valid <= in_valid;
      // Hold led_num/rgb_data between pulses so the core sees stable values.
      if (in_valid) begin
        out_idx <= in_idx;
        out_rgb <= {scale_ch(in_rgb[23:16], bright),
                    scale_ch(in_rgb[15:8],  bright),
                    scale_ch(in_rgb[7:0],   bright)};
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl
// Bus-mapped frame controller in front of one ws2812 driver core. Holds a
// NUM_LEDS x 24b framebuffer and streams whole, brightness-scaled frames into
// the core's led_num/rgb_data/write port on a CPU commit or on the auto-refresh
// timer.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   addr[8:0]      word address; addr[8]=1 selects framebuffer entry addr[7:0]
//   wdata[31:0]    write data
//   wen, ren       single-cycle write / read strobes
//   rdata[31:0]    read data, valid while ready=1
//   ready          one-cycle response pulse
//   led_num, rgb_data, write   to the ws2812 core
//   busy           frame stream in progress
//
// Bus handshake: every cycle with wen or ren high is accepted unconditionally
// and answered by exactly one ready pulse on the following cycle. If wen and
// ren are both high the write is performed and the read is dropped, so the
// single ready belongs to the write. For reads, rdata is valid only in the
// ready cycle.
//
// Stream pipeline: c0 issue port-B read, c1 RAM data, c2 scaled outputs with
// write=1. A CPU framebuffer read owns port B for its cycle and simply delays
// the streamer by one cycle; idx does not advance, so no LED is skipped.
import ws2812_frame_ctrl_pkg::*;

module ws2812_frame_ctrl #(
  parameter int NUM_LEDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write,
  output logic        busy
);

  // RAM depth rounded up to a power of two so the index slice matches exactly.
  localparam int         AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int         DEPTH      = 1 << AW;
  localparam logic [8:0] NUM_LEDS_W = 9'(NUM_LEDS);
  localparam logic [7:0] LAST_IDX   = 8'(NUM_LEDS - 1);

  // Configuration / status state
  logic        auto_en;
  logic [7:0]  bright;
  logic [23:0] period;
  logic [23:0] timer;
  logic [7:0]  frame_cnt;
  logic        pending;

  // Streamer state
  logic [1:0]  state;
  logic [7:0]  idx;
  logic [7:0]  frame_bright;
  logic        s1_valid;
  logic [7:0]  s1_idx;

  // Framebuffer
  logic [23:0] fb [DEPTH];
  logic [23:0] fb_q;
  logic [AW-1:0] port_b_addr;

  // Bus response state
  logic [31:0] reg_rdata;
  logic        fb_rd_q;
  logic        fb_rd_ok_q;

  // Decoded bus cycle
  logic addr_in_range;
  logic cpu_fb_rd;
  logic cpu_reg_rd;
  logic ctrl_wr;
  logic period_wr;
  logic commit_req;
  logic timer_run;
  logic timer_fire;
  logic stream_issue;

  ctrl_t   ctrl_rd;
  status_t status_rd;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:24];

  assign addr_in_range = {1'b0, addr[7:0]} < NUM_LEDS_W;
  assign cpu_fb_rd     = ren && !wen && addr[8];
  assign cpu_reg_rd    = ren && !wen && !addr[8];
  assign ctrl_wr       = wen && !addr[8] && (addr[7:0] == REG_CTRL);
  assign period_wr     = wen && !addr[8] && (addr[7:0] == REG_PERIOD);
  assign commit_req    = ctrl_wr && wdata[CTRL_COMMIT_BIT];

  // Timer counts PERIOD..1; reaching the bottom raises pending and reloads,
  // giving one commit every PERIOD cycles.
  assign timer_run  = auto_en && (period != 24'd0);
  assign timer_fire = timer_run && !period_wr && (timer <= 24'd1);

  // CPU has fixed priority on port B.
  assign stream_issue = (state == ST_STREAM) && !cpu_fb_rd;
  assign port_b_addr  = cpu_fb_rd ? addr[AW-1:0] : idx[AW-1:0];

  assign busy = (state != ST_IDLE);

  always_comb begin
    ctrl_rd         = '0;
    ctrl_rd.bright  = bright;
    ctrl_rd.auto_en = auto_en;
    status_rd           = '0;
    status_rd.frame_cnt = frame_cnt;
    status_rd.pending   = pending;
    status_rd.busy      = busy;
  end

  // Framebuffer: port A CPU writes, port B registered read. No reset so it
  // maps onto block RAM; a same-cycle write and read of one entry returns
  // the old contents.
  always_ff @(posedge clk) begin
    if (wen && addr[8] && addr_in_range) begin
      fb[addr[AW-1:0]] <= wdata[23:0];
    end
    fb_q <= fb[port_b_addr];
  end

  // Bus responses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready      <= 1'b0;
      reg_rdata  <= 32'h0;
      fb_rd_q    <= 1'b0;
      fb_rd_ok_q <= 1'b0;
    end else begin
      ready      <= wen || ren;
      fb_rd_q    <= cpu_fb_rd;
      fb_rd_ok_q <= cpu_fb_rd && addr_in_range;
      reg_rdata  <= 32'h0;
      if (cpu_reg_rd) begin
        case (addr[7:0])
          REG_CTRL:   reg_rdata <= ctrl_rd;
          REG_STATUS: reg_rdata <= status_rd;
          REG_PERIOD: reg_rdata <= {8'h00, period};
          default:    reg_rdata <= 32'h0;
        endcase
      end
    end
  end

  // Framebuffer read data comes straight from the RAM output register.
  assign rdata = fb_rd_q ? (fb_rd_ok_q ? {8'h00, fb_q} : 32'h0) : reg_rdata;

  // Registers, timer, pending flag and stream FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      auto_en      <= 1'b0;
      bright       <= BRIGHT_RESET;
      period       <= 24'd0;
      timer        <= 24'd0;
      pending      <= 1'b0;
      frame_cnt    <= 8'd0;
      state        <= ST_IDLE;
      idx          <= 8'd0;
      frame_bright <= BRIGHT_RESET;
      s1_valid     <= 1'b0;
      s1_idx       <= 8'd0;
    end else begin
      if (ctrl_wr) begin
        auto_en <= wdata[CTRL_AUTO_BIT];
        bright  <= wdata[15:8];
      end
      if (period_wr) begin
        period <= wdata[23:0];
      end

      if (period_wr) begin
        timer <= wdata[23:0];
      end else if (!timer_run || timer <= 24'd1) begin
        timer <= period;
      end else begin
        timer <= timer - 24'd1;
      end

      // One-deep request: a new commit wins over the clear, so a commit that
      // lands on the frame-start cycle still produces a following frame.
      if (commit_req || timer_fire) begin
        pending <= 1'b1;
      end else if (state == ST_IDLE && pending) begin
        pending <= 1'b0;
      end

      s1_valid <= stream_issue;
      if (stream_issue) begin
        s1_idx <= idx;
      end

      case (state)
        ST_IDLE: begin
          if (pending) begin
            state        <= ST_STREAM;
            idx          <= 8'd0;
            frame_bright <= bright;
          end
        end
        ST_STREAM: begin
          if (stream_issue) begin
            if (idx == LAST_IDX) begin
              state <= ST_DRAIN;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          // Once the last read has left the RAM stage, the scaler is
          // presenting the final LED this cycle; the frame is done.
          if (!s1_valid) begin
            frame_cnt <= frame_cnt + 8'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ws2812_frame_ctrl_scale u_scale (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s1_valid),
    .in_idx    (s1_idx),
    .in_rgb    (fb_q),
    .bright    (frame_bright),
    .out_valid (write),
    .out_idx   (led_num),
    .out_rgb   (rgb_data)
  );

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
module tb_ws2812_frame_ctrl;

  localparam int N = 64;
  localparam logic [8:0] A_CTRL   = 9'h000;
  localparam logic [8:0] A_STATUS = 9'h001;
  localparam logic [8:0] A_PERIOD = 9'h002;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;
  logic        busy;

  ws2812_frame_ctrl #(.NUM_LEDS(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wdata    (wdata),
    .wen      (wen),
    .ren      (ren),
    .rdata    (rdata),
    .ready    (ready),
    .led_num  (led_num),
    .rgb_data (rgb_data),
    .write    (write),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_bus_q[$];  // bit 32: compare rdata
  logic [31:0] exp_led_q[$];  // {led_num, rgb_data}
  int start_q[$];
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  logic [23:0] fb_m [256];
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] scale24(input logic [23:0] c, input logic [7:0] b);
    logic [23:0] r;
    logic [31:0] p;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = 32'(c[k*8 +: 8]) * (32'(b) + 32'd1);
      r[k*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

  function automatic logic [8:0] fba(input int i);
    return {1'b1, 8'(i)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (ready === 1'b1) begin
        if (exp_bus_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_ready: got unexpected ready expected none");
        end else begin
          mon_e = exp_bus_q.pop_front();
          if (mon_e[32]) check("bus_rdata", rdata, mon_e[31:0]);
        end
      end
      if (write === 1'b1) begin
        if (led_num == 8'd0) begin
          start_q.push_back(cyc);
          first_wr_cyc = cyc;
        end
        if (led_num == 8'(N - 1)) last_wr_cyc = cyc;
        if (exp_led_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL led_write: got unexpected led %0d rgb %h expected none", led_num, rgb_data);
        end else begin
          check("led_write", {led_num, rgb_data}, exp_led_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    exp_bus_q.push_back({1'b0, 32'h0});
    if (a[8] && int'(a[7:0]) < N) fb_m[a[7:0]] = d[23:0];
    addr = a;
    wdata = d;
    wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, input logic [31:0] exp);
    exp_bus_q.push_back({1'b1, exp});
    addr = a;
    ren = 1'b1;
    tick();
    ren = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < N; i++) exp_led_q.push_back({8'(i), scale24(fb_m[i], b)});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_led_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_led_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got %0d leds outstanding busy=%b expected 0 outstanding busy=0",
               name, exp_led_q.size(), busy);
      exp_led_q.delete();
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    addr = '0;
    wdata = '0;
    wen = 1'b0;
    ren = 1'b0;
    for (int i = 0; i < 256; i++) fb_m[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_write", {31'h0, write}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_led_num", {24'h0, led_num}, 32'h0);
    check("rst_rgb", {8'h0, rgb_data}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    bus_read(A_CTRL, 32'h0000FF00);
    bus_read(A_STATUS, 32'h0);
    bus_read(A_PERIOD, 32'h0);

    // Fill framebuffer
    for (int i = 0; i < N; i++) bus_write(fba(i), 32'(i) * 32'h00010101);

    // T2: commit at full brightness, consecutive pulses
    push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    wait_drain(300, "t2");
    check("t2_span", 32'(last_wr_cyc - first_wr_cyc), 32'd63);
    bus_read(A_STATUS, 32'h00000100);
    bus_read(A_CTRL, 32'h0000FF00);

    // T3: scaling
    bus_write(fba(0), 32'h00FF8001);
    push_frame(8'd127);
    bus_write(A_CTRL, 32'h00007F02);
    wait_drain(300, "t3_b127");
    push_frame(8'd0);
    bus_write(A_CTRL, 32'h00000002);
    wait_drain(300, "t3_b0");
    bus_read(fba(0), 32'h00FF8001);

    // T4: CPU framebuffer reads interleaved with a stream
    push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    for (int r = 0; r < 20; r++) begin
      bus_read(fba(5), 32'h00050505);
      tick();
      tick();
    end
    wait_drain(400, "t4");

    // Brightness held for the frame in flight
    push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    repeat (10) tick();
    bus_write(A_CTRL, 32'h00000000);
    wait_drain(300, "hold");
    bus_write(A_CTRL, 32'h0000FF00);
    bus_read(A_STATUS, 32'h00000500);

    // T5: auto refresh every 1000 cycles
    bus_write(A_PERIOD, 32'd1000);
    bus_read(A_PERIOD, 32'd1000);
    repeat (3) push_frame(8'hFF);
    start_q.delete();
    bus_write(A_CTRL, 32'h0000FF01);
    wait_drain(3600, "t5_auto");
    bus_write(A_CTRL, 32'h0000FF00);
    check("t5_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() >= 3) begin
      check("t5_gap1", 32'(start_q[1] - start_q[0]), 32'd1000);
      check("t5_gap2", 32'(start_q[2] - start_q[1]), 32'd1000);
    end
    bus_read(A_STATUS, 32'h00000800);

    // T5: commits during busy merge into one extra frame
    repeat (2) push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    repeat (4) tick();
    bus_write(A_CTRL, 32'h0000FF02);
    bus_write(A_CTRL, 32'h0000FF02);
    bus_read(A_STATUS, 32'h00000803);
    wait_drain(400, "t5_merge");
    repeat (200) tick();
    bus_read(A_STATUS, 32'h00000A00);

    // T6: bounds, unmapped, write wins over read
    bus_write(fba(200), 32'h00123456);
    bus_read(fba(200), 32'h0);
    bus_read(fba(8), 32'h00080808);
    bus_read(fba(63), 32'h003F3F3F);
    bus_read(fba(64), 32'h0);
    bus_read(9'h005, 32'h0);
    bus_write(9'h005, 32'hDEADBEEF);
    bus_read(9'h005, 32'h0);
    exp_bus_q.push_back({1'b0, 32'h0});
    addr = A_PERIOD;
    wdata = 32'h00000077;
    wen = 1'b1;
    ren = 1'b1;
    tick();
    wen = 1'b0;
    ren = 1'b0;
    bus_read(A_PERIOD, 32'h00000077);
    bus_write(A_PERIOD, 32'h0);

    // T6: frame counter wrap 255 -> 0
    for (int f = 0; f < 245; f++) begin
      push_frame(8'hFF);
      bus_write(A_CTRL, 32'h0000FF02);
      wait_drain(300, "wrap");
    end
    bus_read(A_STATUS, 32'h0000FF00);
    push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    wait_drain(300, "wrap_last");
    bus_read(A_STATUS, 32'h00000000);

    // T1: reset in the middle of a stream
    bus_write(A_PERIOD, 32'd5);
    push_frame(8'hFF);
    bus_write(A_CTRL, 32'h0000FF02);
    repeat (20) tick();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_write", {31'h0, write}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_ready", {31'h0, ready}, 32'h0);
    exp_led_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) tick();
    bus_read(A_CTRL, 32'h0000FF00);
    bus_read(A_STATUS, 32'h0);
    bus_read(A_PERIOD, 32'h0);
    repeat (3) tick();

    check("led_q_empty", 32'(exp_led_q.size()), 32'd0);
    check("bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
